tdm_demux8: RTL and testbench
=============================

# tdm_demux8

Time-division demultiplexer: receives one sample per accepted cycle on a shared serial lane and distributes consecutive samples into eight parallel channel registers. It is the receive end of the 8:1 channel multiplexer: the mux side selects I[0]..I[7] in slot order onto one wire, and this block rebuilds the 8-channel word. A slot counter, aligned by a frame sync marker, drives it. A completed frame is published atomically with a one-cycle strobe.

## Interface
- WIDTH, 1, bits per channel sample
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present on in_data this cycle
- in_sync  in  1  qualifies in_data as slot 0 of a frame; ignored when in_valid=0
- in_data  in  WIDTH  serial sample
- out_data  out  8*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  one-cycle pulse: out_data just updated with a complete frame
- frame_err  out  1  one-cycle pulse: framing violation detected
- par_err  out  1  one-cycle pulse with out_valid on parity mismatch; constant 0 without the macro
- slot  out  4  next expected slot index (0..7, or 0..8 with parity)

## Operation
- One clock domain. Reset is asynchronous and active-low.
- States:
  - HUNT (reset state): discard all samples until in_valid&in_sync. That sample goes to shadow channel 0, slot becomes 1, state becomes COLLECT.
  - COLLECT: each in_valid sample is written to shadow[slot] and slot increments.
- in_valid=0: full stall. No state, slot or register change.
- Last data slot (7) accepted, no parity: out_data <= {sample, shadow[6:0]}, out_valid pulses, slot wraps to 0. State stays COLLECT.
- At slot 0 in COLLECT:
  - in_valid&in_sync: new frame, normal capture.
  - in_valid&!in_sync: frame_err pulses, sample discarded, state becomes HUNT, slot becomes 0.
- in_valid&in_sync at slot 1..7 (or 8): frame_err pulses and the partial frame is discarded. The sample is taken as slot 0 of a new frame, so shadow[0] is written and slot becomes 1. out_data is unchanged.
- out_data changes only on frame completion and holds between frames. Partial frames are never visible.
- Shadow registers are not cleared between frames. Every slot is overwritten before publication.

## Timing
- Reset values: out_data=0, out_valid=0, frame_err=0, par_err=0, slot=0, state=HUNT.
- Latency: out_data, out_valid and par_err are registered. They appear the cycle after the final slot sample is accepted.
- Back-to-back frames at full rate: 8 cycles per frame (9 with parity). out_valid fires every 8th (9th) cycle with no bubbles.
- frame_err is registered and appears the cycle after the offending sample.
- rst_n asserted mid-frame: all outputs clear immediately and the partial frame is lost. After release, the block waits in HUNT for the next sync.
- Frame completion and frame_err never occur in the same cycle.

## Configuration
- Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - Each frame has 9 slots. Slot 8 is a parity sample equal to the bitwise XOR of channels 0..7, and in_sync must be 0 there.
  - Accepting slot 7 only stores it to shadow. Accepting slot 8 publishes out_data and pulses out_valid.
  - par_err pulses with out_valid when the parity sample differs from the computed XOR. out_data is still published.
  - slot counts 0..8.
- Undefined: 8-slot frames, par_err tied 0, slot counts 0..7.

## Test plan
- Reset then one frame, WIDTH=4, samples 1..8, sync on first -> one cycle after the 8th sample: out_data=32'h87654321, out_valid=1 for exactly one cycle, slot=0.
- Two frames back-to-back with in_valid held high: samples 1..8 then 9,A,B,C,D,E,F,0 -> out_valid on cycles 9 and 17; second out_data=32'h0FEDCBA9.
- in_valid toggling 1/0 every cycle across one frame -> same result as the first scenario, with out_valid 16 cycles after first accept.
- Sync reasserted at slot 5 -> frame_err pulse, out_data keeps previous value, and the next 7 samples complete a frame whose channel 0 is the resync sample.
- Slot 0 sample without sync -> frame_err, HUNT; later samples ignored until sync; rst_n pulsed mid-frame -> all outputs 0 asynchronously.
- With TDM_DEMUX_PARITY_EN: samples 1..8 then parity 4'h8 -> out_valid, par_err=0; parity 4'h9 -> out_valid, par_err=1.

Source files
------------

// File: rtl/tdm_demux8_if.sv
// Bus bundle for the 8-channel TDM demultiplexer: serial sample lane in, rebuilt frame out.
// The master modport drives the serial lane and the slave modport (the demux) drives the frame outputs.
interface tdm_demux8_if #(
  parameter int WIDTH = 1
);
  logic               in_valid;
  logic               in_sync;
  logic [WIDTH-1:0]   in_data;
  logic [8*WIDTH-1:0] out_data;
  logic               out_valid;
  logic               frame_err;
  logic               par_err;
  logic [3:0]         slot;

  modport master (
    output in_valid, in_sync, in_data,
    input  out_data, out_valid, frame_err, par_err, slot
  );

  modport slave (
    input  in_valid, in_sync, in_data,
    output out_data, out_valid, frame_err, par_err, slot
  );
endinterface

// File: rtl/tdm_demux8.sv
// Time-division demultiplexer: sync-aligned slot counter fills eight shadow channels, then publishes them atomically.
// Optional TDM_DEMUX_PARITY_EN adds a ninth XOR parity slot per frame and drives par_err.
module tdm_demux8 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux8_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [3:0] LAST_SLOT = 4'd8;
`else
  localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t             state;
  logic [3:0]         slot_q;
  logic [WIDTH-1:0]   shadow [8];

  logic [8*WIDTH-1:0] data_p1;
  logic               vld_p1;
  logic               ferr_p1;

  logic               store_en;
  logic [2:0]         store_idx;
  logic [8*WIDTH-1:0] frame_word;

`ifdef TDM_DEMUX_PARITY_EN
  logic               perr_p1;

  function automatic logic [WIDTH-1:0] frame_parity(input logic [8*WIDTH-1:0] word);
    logic [WIDTH-1:0] acc;
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      acc = acc ^ word[k*WIDTH +: WIDTH];
    end
    return acc;
  endfunction
`endif

  // A sync sample always lands in channel 0; otherwise data slots 1..7 are stored in place.
  always_comb begin
    store_en  = 1'b0;
    store_idx = 3'd0;
    if (bus.in_valid) begin
      if (bus.in_sync) begin
        store_en  = 1'b1;
        store_idx = 3'd0;
      end else if (state == COLLECT && slot_q != 4'd0 && slot_q < 4'd8) begin
        store_en  = 1'b1;
        store_idx = slot_q[2:0];
      end
    end
  end

  // Without parity the last channel bypasses the shadow so the frame publishes on its own accept.
  always_comb begin
    frame_word = '0;
    for (int k = 0; k < 7; k++) begin
      frame_word[k*WIDTH +: WIDTH] = shadow[k];
    end
`ifdef TDM_DEMUX_PARITY_EN
    frame_word[7*WIDTH +: WIDTH] = shadow[7];
`else
    frame_word[7*WIDTH +: WIDTH] = bus.in_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      shadow[store_idx] <= bus.in_data;
    end
  end

  // Stage p1: registered frame, strobes, slot counter and framing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      slot_q  <= 4'd0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_p1 <= 1'b0;
`endif
    end else begin
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_p1 <= 1'b0;
`endif
      if (bus.in_valid) begin
        case (state)
          HUNT: begin
            if (bus.in_sync) begin
              state  <= COLLECT;
              slot_q <= 4'd1;
            end
          end
          COLLECT: begin
            if (bus.in_sync) begin
              slot_q <= 4'd1;
              if (slot_q != 4'd0) begin
                ferr_p1 <= 1'b1;
              end
            end else if (slot_q == 4'd0) begin
              ferr_p1 <= 1'b1;
              state   <= HUNT;
            end else if (slot_q == LAST_SLOT) begin
              data_p1 <= frame_word;
              vld_p1  <= 1'b1;
              slot_q  <= 4'd0;
`ifdef TDM_DEMUX_PARITY_EN
              perr_p1 <= (bus.in_data != frame_parity(frame_word));
`endif
            end else begin
              slot_q <= slot_q + 4'd1;
            end
          end
          default: begin
            state  <= HUNT;
            slot_q <= 4'd0;
          end
        endcase
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_valid = vld_p1;
  assign bus.frame_err = ferr_p1;
  assign bus.slot      = slot_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err   = perr_p1;
`else
  assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8 (WIDTH=4) against a queue-based frame model.
// Define TDM_DEMUX_PARITY_EN for both bench and RTL to exercise the parity slot.
module tb_tdm_demux8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int NSLOT = 9;
`else
  localparam int NSLOT = 8;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tdm_demux8_if #(.WIDTH(4)) bus ();

  tdm_demux8 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: hunting flag plus the list of samples gathered for the current frame.
  bit          m_hunt;
  logic [3:0]  m_frame[$];
  logic [31:0] exp_data;
  logic        exp_vld;
  logic        exp_ferr;
  logic        exp_perr;
  logic [3:0]  exp_slot;

  function automatic logic [3:0] xor8(input logic [31:0] w);
    logic [3:0] a;
    a = 4'h0;
    for (int k = 0; k < 8; k++) a = a ^ w[k*4 +: 4];
    return a;
  endfunction

  task automatic model_reset();
    m_hunt = 1'b1;
    m_frame.delete();
    exp_data = 32'h0;
    exp_vld  = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    exp_slot = 4'd0;
  endtask

  task automatic model_apply(input logic v, input logic s, input logic [3:0] d);
    exp_vld  = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    if (v) begin
      if (m_hunt) begin
        if (s) begin
          m_hunt = 1'b0;
          m_frame.delete();
          m_frame.push_back(d);
        end
      end else if (s) begin
        if (m_frame.size() != 0) exp_ferr = 1'b1;
        m_frame.delete();
        m_frame.push_back(d);
      end else if (m_frame.size() == 0) begin
        exp_ferr = 1'b1;
        m_hunt   = 1'b1;
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == NSLOT) begin
          for (int k = 0; k < 8; k++) exp_data[k*4 +: 4] = m_frame[k];
          exp_vld = 1'b1;
          if (NSLOT == 9) exp_perr = (m_frame[8] != xor8(exp_data));
          m_frame.delete();
        end
      end
    end
    exp_slot = m_hunt ? 4'd0 : 4'(m_frame.size());
  endtask

  // One clock: drive on the falling edge, advance the model, settle just after the rising edge.
  task automatic step(input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = d;
    model_apply(v, s, d);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] w);
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, w[i*4 +: 4]);
    if (NSLOT == 9) step(1'b1, 1'b0, xor8(w));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected %h", bus.out_data, 32'h0); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", bus.par_err); end
    checks++; if (bus.slot !== 4'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", bus.slot); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, 4'(i + 1));
      checks++; if (bus.slot !== exp_slot) begin errors++; $display("FAIL single_slot[%0d]: got %0d expected %0d", i, bus.slot, exp_slot); end
      if (i < NSLOT - 1) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid[%0d]: got %b expected 0", i, bus.out_valid); end
      end
    end
    if (NSLOT == 9) step(1'b1, 1'b0, 4'h8);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h87654321) begin errors++; $display("FAIL single_data: got %h expected %h", bus.out_data, 32'h87654321); end
    checks++; if (bus.slot !== 4'd0) begin errors++; $display("FAIL single_slot_wrap: got %0d expected 0", bus.slot); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL single_ferr: got %b expected 0", bus.frame_err); end
    step(1'b0, 1'b0, 4'h0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_len: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h87654321) begin errors++; $display("FAIL single_hold: got %h expected %h", bus.out_data, 32'h87654321); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1, seen;
    int first_c, second_c, c;
    w0 = 32'h87654321;
    w1 = 32'h0FEDCBA9;
    first_c = -1; second_c = -1; seen = 32'h0; c = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (i < 8) step(1'b1, i == 0, (f == 0) ? w0[i*4 +: 4] : w1[i*4 +: 4]);
        else       step(1'b1, 1'b0, xor8((f == 0) ? w0 : w1));
        c++;
        if (bus.out_valid === 1'b1) begin
          if (first_c < 0) first_c = c + 1;
          else begin second_c = c + 1; seen = bus.out_data; end
        end
      end
    end
    checks++; if (first_c != NSLOT + 1) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected %0d", first_c, NSLOT + 1); end
    checks++; if (second_c != 2*NSLOT + 1) begin errors++; $display("FAIL b2b_second_cycle: got %0d expected %0d", second_c, 2*NSLOT + 1); end
    checks++; if (seen !== 32'h0FEDCBA9) begin errors++; $display("FAIL b2b_data: got %h expected %h", seen, 32'h0FEDCBA9); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    int c, hit_c, extra;
    w = 32'h87654321;
    c = 0; hit_c = -1; extra = 0;
    for (int i = 0; i < NSLOT; i++) begin
      step(1'b1, i == 0, (i < 8) ? w[i*4 +: 4] : xor8(w));
      c++;
      if (bus.out_valid === 1'b1) begin
        if (hit_c < 0) hit_c = c + 1; else extra++;
      end
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
      c++;
      if (bus.out_valid === 1'b1) extra++;
    end
    checks++; if (hit_c != 2*NSLOT) begin errors++; $display("FAIL stall_valid_cycle: got %0d expected %0d", hit_c, 2*NSLOT); end
    checks++; if (extra != 0) begin errors++; $display("FAIL stall_extra_valid: got %0d expected 0", extra); end
    checks++; if (bus.out_data !== 32'h87654321) begin errors++; $display("FAIL stall_data: got %h expected %h", bus.out_data, 32'h87654321); end
  endtask

  task automatic test_resync();
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 4'(i + 1));
    step(1'b1, 1'b1, 4'hA);
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL resync_ferr: got %b expected 1", bus.frame_err); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL resync_no_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h87654321) begin errors++; $display("FAIL resync_hold: got %h expected %h", bus.out_data, 32'h87654321); end
    checks++; if (bus.slot !== 4'd1) begin errors++; $display("FAIL resync_slot: got %0d expected 1", bus.slot); end
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, (i <= 5) ? 4'(4'hA + i) : 4'(i - 5));
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL resync_ferr_len[%0d]: got %b expected 0", i, bus.frame_err); end
    end
    if (NSLOT == 9) step(1'b1, 1'b0, xor8(32'h21FEDCBA));
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL resync_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h21FEDCBA) begin errors++; $display("FAIL resync_data: got %h expected %h", bus.out_data, 32'h21FEDCBA); end
  endtask

  task automatic test_hunt();
    step(1'b1, 1'b0, 4'h3);
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL hunt_ferr: got %b expected 1", bus.frame_err); end
    checks++; if (bus.slot !== 4'd0) begin errors++; $display("FAIL hunt_slot: got %0d expected 0", bus.slot); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 4'($urandom));
      checks++; if (bus.slot !== 4'd0 || bus.frame_err !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL hunt_ignore[%0d]: got slot=%0d ferr=%b vld=%b expected 0 0 0", i, bus.slot, bus.frame_err, bus.out_valid);
      end
    end
    send_frame(32'h13572468);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h13572468) begin
      errors++; $display("FAIL hunt_relock: got vld=%b data=%h expected 1 %h", bus.out_valid, bus.out_data, 32'h13572468);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 4'hC);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_data !== 32'h0 || bus.slot !== 4'd0 || bus.out_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.par_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got data=%h slot=%0d vld=%b ferr=%b perr=%b expected all 0", bus.out_data, bus.slot, bus.out_valid, bus.frame_err, bus.par_err);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'h5);
    checks++; if (bus.slot !== 4'd0 || bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL async_reset_hunt: got slot=%0d ferr=%b expected 0 0", bus.slot, bus.frame_err);
    end
  endtask

  task automatic test_random();
    logic v, s;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0);
      step(v, s, 4'($urandom));
      checks++; if (bus.out_valid !== exp_vld || bus.frame_err !== exp_ferr || bus.par_err !== exp_perr ||
                    bus.slot !== exp_slot || bus.out_data !== exp_data) begin
        errors++;
        $display("FAIL random[%0d]: got vld=%b ferr=%b perr=%b slot=%0d data=%h expected %b %b %b %0d %h",
                 n, bus.out_valid, bus.frame_err, bus.par_err, bus.slot, bus.out_data,
                 exp_vld, exp_ferr, exp_perr, exp_slot, exp_data);
      end
    end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 4'(i + 1));
    step(1'b1, 1'b0, 4'h8);
    checks++; if (bus.out_valid !== 1'b1 || bus.par_err !== 1'b0) begin
      errors++; $display("FAIL parity_good: got vld=%b perr=%b expected 1 0", bus.out_valid, bus.par_err);
    end
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 4'(i + 1));
    step(1'b1, 1'b0, 4'h9);
    checks++; if (bus.out_valid !== 1'b1 || bus.par_err !== 1'b1 || bus.out_data !== 32'h87654321) begin
      errors++; $display("FAIL parity_bad: got vld=%b perr=%b data=%h expected 1 1 %h", bus.out_valid, bus.par_err, bus.out_data, 32'h87654321);
    end
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 4'(i + 1));
    step(1'b1, 1'b1, 4'h8);
    checks++; if (bus.frame_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.slot !== 4'd1) begin
      errors++; $display("FAIL parity_sync_slot8: got ferr=%b vld=%b slot=%0d expected 1 0 1", bus.frame_err, bus.out_valid, bus.slot);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_resync();
    test_hunt();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
